v_elem_streamer: RTL and testbench
==================================

// Module: v_elem_streamer
// PURPOSE
//  Element-read sequencer on the vector register file's element read port (el_rd_addr/el_addr -> el_data_out).
//  On start, walks a register group base_reg..base_reg+LMUL-1 element by element at the given SEW.
//  Streams vl elements, zero-extended, to a scalar/lane consumer over a valid/ready interface.
//  Reader counterpart to the regfile element/register write path: serialises what the write ports stored.
// PARAMETERS
//  VLEN_BITS  128  bits per vector register
//  ELEN       32   output element width (max SEW)
//  NREGS      32   number of vector registers (5-bit register address)
// PORTS
//  clk          in   1   clock, all state on posedge
//  rst          in   1   synchronous active-high reset
//  start        in   1   begin a stream; sampled only in IDLE
//  base_reg     in   5   first register of the group
//  sew          in   3   0=8b, 1=16b, 2=32b, other=8b
//  lmul         in   3   0=1 reg, 1=2 regs, 2=4 regs, other=1 reg
//  vl           in   7   elements to stream (clamped to VLMAX)
//  rd_reg_addr  out  5   to regfile el_rd_addr
//  rd_el_addr   out  5   to regfile el_addr
//  rd_data      in   32  from regfile el_data_out (combinational, same cycle)
//  out_valid    out  1   out_data/out_idx/out_last hold a valid element
//  out_ready    in   1   consumer accepts element when out_valid & out_ready
//  out_data     out  32  element, zero-extended from SEW
//  out_idx      out  7   element index 0..vl-1 within the group
//  out_last     out  1   element is index vl-1
//  busy         out  1   high outside IDLE
//  done         out  1   one-cycle pulse when stream completes
// BEHAVIOUR
//  - Reset: state=IDLE; out_valid, out_last, busy, done = 0; out_data, out_idx, rd_reg_addr, rd_el_addr = 0.
//  - start, base_reg, sew, lmul, vl latched in IDLE on start; later input changes ignored until IDLE.
//  - EPR (elements/reg) = 16>>sew_eff; VLMAX = EPR*(1<<lmul_eff); vl_eff = min(vl, VLMAX).
//  - States: IDLE -> (start, vl_eff!=0) RUN; IDLE -> (start, vl_eff==0) FIN; RUN -> (last element captured) DRAIN;
//    DRAIN -> (final handshake) FIN; FIN -> IDLE (done=1 for exactly this cycle, busy still 1).
//  - RUN: rd_reg_addr/rd_el_addr driven from registered counters (reg_cnt, el_cnt). Capture when
//    !out_valid | out_ready: out_data <= rd_data masked to SEW, out_idx <= elem_cnt, out_last <= (elem_cnt==vl_eff-1),
//    out_valid <= 1; advance counters same edge.
//  - Counter advance: el_cnt==EPR-1 -> el_cnt=0, reg_cnt=reg_cnt+1 (5-bit, 31 wraps to 0); else el_cnt+1.
//  - Throughput: one element per cycle while out_ready held high; first out_valid 2 cycles after start edge
//    (cycle 1: RUN addresses driven, capture at end of cycle 1).
//  - Backpressure: out_valid & !out_ready -> out_data/out_idx/out_last and counters held stable; no element dropped or duplicated.
//  - DRAIN: no reads; waits for handshake on out_last element; out_valid <= 0 on that handshake.
//  - rd_* outputs hold last value outside RUN (don't-care for regfile, must not be X).
//  - start while busy ignored, no effect on stream.
//  - rst mid-stream: next cycle IDLE, out_valid=0, no done pulse; pending element discarded.
//  - Mask: sew 8 -> {24'b0, rd_data[7:0]}; 16 -> {16'b0, rd_data[15:0]}; 32 -> rd_data.
// TESTING
//  1. sew=2, lmul=0, base=3, vl=4, out_ready=1, v3=0x44444444_33333333_22222222_11111111 -> out_data
//     0x11111111..0x44444444 on 4 consecutive cycles, idx 0..3, out_last on idx 3, done 1 cycle later.
//  2. sew=0, lmul=1, base=30, vl=20 -> reads v30 el 0..15 then v31 el 0..3; each out_data upper 24 bits 0.
//  3. sew=1, lmul=2, base=31, vl=40 -> clamp to 32; reg sequence 31,0,1,2 (wrap); 32 elements, last idx 31.
//  4. vl=5, out_ready toggled 1,0,0,1,... -> every element seen exactly once, outputs stable while stalled.
//  5. vl=0 -> no out_valid, busy high 1 cycle, done pulse 1 cycle after start.
//  6. rst asserted after 3 of 8 elements -> out_valid=0, busy=0 next cycle, no done; new start runs cleanly from idx 0.

Source files
------------

// File: rtl/v_elem_streamer_if.sv
// Element stream bundle between the streamer (master) and its scalar/lane consumer (slave).
// Latency: none, pure wiring; out_dat/out_idx/out_last are qualified by out_vld.
// Backpressure: the consumer holds out_rdy low to stall; the master keeps the element stable.
// Signals: out_vld/out_rdy handshake, out_dat element (zero-extended), out_idx index, out_last final element.
interface v_elem_streamer_if #(
  parameter int ELEN  = 32,
  parameter int IDX_W = 7
);
  logic             out_vld;
  logic             out_rdy;
  logic [ELEN-1:0]  out_dat;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;

  modport master (output out_vld, output out_dat, output out_idx, output out_last, input out_rdy);
  modport slave  (input out_vld, input out_dat, input out_idx, input out_last, output out_rdy);
endinterface

// File: rtl/v_elem_streamer.sv
// Element-read sequencer: walks base_reg..base_reg+LMUL-1 at SEW and streams vl elements, zero-extended.
// Latency: first out_vld two cycles after the start edge, then one element per cycle while out_rdy is high.
// Backpressure: out_vld & !out_rdy freezes the output element and the read counters; nothing dropped or repeated.
// Ports: clk, rst (sync, active-high); i_start/i_base_reg/i_sew/i_lmul/i_vl command (sampled in IDLE only);
//        o_rd_reg_addr/o_rd_el_addr -> regfile, i_rd_data <- regfile (combinational same cycle);
//        out_if element stream (master); o_busy high outside IDLE; o_done one-cycle completion pulse.
module v_elem_streamer #(
  parameter int VLEN_BITS = 128,
  parameter int ELEN      = 32,
  parameter int NREGS     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_start,
  input  logic [$clog2(NREGS)-1:0] i_base_reg,
  input  logic [2:0]               i_sew,
  input  logic [2:0]               i_lmul,
  input  logic [6:0]               i_vl,
  output logic [$clog2(NREGS)-1:0] o_rd_reg_addr,
  output logic [4:0]               o_rd_el_addr,
  input  logic [ELEN-1:0]          i_rd_data,
  v_elem_streamer_if.master        out_if,
  output logic                     o_busy,
  output logic                     o_done
);

  localparam int RW   = $clog2(NREGS);
  localparam int EPR8 = VLEN_BITS / 8;  // elements per register at 8-bit SEW

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FIN} state_t;

  state_t          r_state;
  logic [RW-1:0]   r_reg_cnt;
  logic [4:0]      r_el_cnt;
  logic [6:0]      r_elem_cnt;
  logic [1:0]      r_sew_eff;
  logic [4:0]      r_epr_m1;
  logic [6:0]      r_vl_m1;
  logic            r_out_vld;
  logic [ELEN-1:0] r_out_dat;
  logic [6:0]      r_out_idx;
  logic            r_out_last;
  logic            r_busy;
  logic            r_done;

  logic [1:0]      w_sew_eff;
  logic [1:0]      w_lmul_eff;
  logic [4:0]      w_epr;
  logic [6:0]      w_vlmax;
  logic [6:0]      w_vl_eff;
  logic [ELEN-1:0] w_mask;
  logic            w_cap;
  logic            w_is_last;

  // Command decode; reserved SEW/LMUL encodings fall back to 8b / 1 register.
  always_comb begin
    w_sew_eff  = 2'd0;
    w_lmul_eff = 2'd0;
    case (i_sew)
      3'd1:    w_sew_eff = 2'd1;
      3'd2:    w_sew_eff = 2'd2;
      default: w_sew_eff = 2'd0;
    endcase
    case (i_lmul)
      3'd1:    w_lmul_eff = 2'd1;
      3'd2:    w_lmul_eff = 2'd2;
      default: w_lmul_eff = 2'd0;
    endcase
  end

  assign w_epr    = 5'(EPR8 >> w_sew_eff);
  assign w_vlmax  = 7'((EPR8 >> w_sew_eff) << w_lmul_eff);
  assign w_vl_eff = (i_vl > w_vlmax) ? w_vlmax : i_vl;

  // The regfile may return neighbouring element bits above SEW; keep only the element.
  always_comb begin
    w_mask = '1;
    case (r_sew_eff)
      2'd0:    w_mask = ELEN'(8'hFF);
      2'd1:    w_mask = ELEN'(16'hFFFF);
      default: w_mask = '1;
    endcase
  end

  // A new element may be captured when the output slot is empty or is being consumed this edge.
  assign w_cap     = !r_out_vld || out_if.out_rdy;
  assign w_is_last = (r_elem_cnt == r_vl_m1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_reg_cnt  <= '0;
      r_el_cnt   <= '0;
      r_elem_cnt <= '0;
      r_sew_eff  <= '0;
      r_epr_m1   <= '0;
      r_vl_m1    <= '0;
      r_out_vld  <= 1'b0;
      r_out_dat  <= '0;
      r_out_idx  <= '0;
      r_out_last <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_reg_cnt  <= i_base_reg;
            r_el_cnt   <= '0;
            r_elem_cnt <= '0;
            r_sew_eff  <= w_sew_eff;
            r_epr_m1   <= w_epr - 5'd1;
            r_vl_m1    <= w_vl_eff - 7'd1;
            r_busy     <= 1'b1;
            if (w_vl_eff == 7'd0) begin
              r_state <= S_FIN;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (w_cap) begin
            r_out_vld  <= 1'b1;
            r_out_dat  <= i_rd_data & w_mask;
            r_out_idx  <= r_elem_cnt;
            r_out_last <= w_is_last;
            if (w_is_last) begin
              // Counters stay on the final address so the read port keeps a stable value.
              r_state <= S_DRAIN;
            end else begin
              r_elem_cnt <= r_elem_cnt + 7'd1;
              if (r_el_cnt == r_epr_m1) begin
                r_el_cnt  <= '0;
                r_reg_cnt <= r_reg_cnt + 1'b1;  // wraps past the top register
              end else begin
                r_el_cnt <= r_el_cnt + 5'd1;
              end
            end
          end
        end
        S_DRAIN: begin
          // The last element is sitting in the output slot; finish once it is taken.
          if (out_if.out_rdy) begin
            r_out_vld <= 1'b0;
            r_state   <= S_FIN;
            r_done    <= 1'b1;
          end
        end
        S_FIN: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_rd_reg_addr   = r_reg_cnt;
  assign o_rd_el_addr    = r_el_cnt;
  assign out_if.out_vld  = r_out_vld;
  assign out_if.out_dat  = r_out_dat;
  assign out_if.out_idx  = r_out_idx;
  assign out_if.out_last = r_out_last;
  assign o_busy          = r_busy;
  assign o_done          = r_done;

endmodule

// File: tb/tb_v_elem_streamer.sv
// Bench for v_elem_streamer: a regfile model feeds the read port, a queue model predicts the stream.
// Latency: n/a.
// Backpressure: out_rdy is driven always-high or in a 1,0,0 pattern depending on the test.
module tb_v_elem_streamer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  base_reg;
  logic [2:0]  sew;
  logic [2:0]  lmul;
  logic [6:0]  vl;
  logic [4:0]  rd_reg_addr;
  logic [4:0]  rd_el_addr;
  logic [31:0] rd_data;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  v_elem_streamer_if #(.ELEN(32), .IDX_W(7)) sif ();

  v_elem_streamer #(.VLEN_BITS(128), .ELEN(32), .NREGS(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (start),
    .i_base_reg   (base_reg),
    .i_sew        (sew),
    .i_lmul       (lmul),
    .i_vl         (vl),
    .o_rd_reg_addr(rd_reg_addr),
    .o_rd_el_addr (rd_el_addr),
    .i_rd_data    (rd_data),
    .out_if       (sif.master),
    .o_busy       (busy),
    .o_done       (done)
  );

  // Register file model: returns the 32 bits starting at the addressed element,
  // so bits above SEW carry neighbouring elements the DUT must strip.
  logic [127:0] vreg [32];
  int           rf_sw;
  always_comb rd_data = 32'(vreg[rd_reg_addr] >> (int'(rd_el_addr) * rf_sw));

  typedef struct {
    logic [31:0] dat;
    logic [6:0]  idx;
    logic        last;
  } exp_t;

  typedef struct {
    logic [31:0] dat;
    logic [6:0]  idx;
    logic        last;
    int          cyc;
  } obs_t;

  exp_t exp_q[$];
  obs_t obs_q[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int rdy_mode = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h at cycle %0d", name, act, req, cyc);
    end
  endtask

  // Expected stream derived directly from the element layout of the register group.
  function automatic int model_push(input int b, input int s, input int l, input int v);
    int sw, nregs, epr, n;
    exp_t e;
    sw    = (s == 1) ? 16 : (s == 2) ? 32 : 8;
    nregs = (l == 1) ? 2 : (l == 2) ? 4 : 1;
    epr   = 128 / sw;
    n     = (v < epr * nregs) ? v : epr * nregs;
    for (int i = 0; i < n; i++) begin
      logic [127:0] word;
      logic [31:0]  full;
      word   = vreg[(b + i / epr) % 32] >> ((i % epr) * sw);
      full   = word[31:0];
      e.dat  = (sw == 32) ? full : (sw == 16) ? {16'h0, full[15:0]} : {24'h0, full[7:0]};
      e.idx  = 7'(i);
      e.last = (i == n - 1);
      exp_q.push_back(e);
    end
    return n;
  endfunction

  // Compare process: every non-reset cycle, check the presented element and handshake bookkeeping.
  logic        p_vld = 1'b0;
  logic        p_rdy = 1'b0;
  logic [31:0] p_dat;
  logic [6:0]  p_idx;
  logic        p_last;

  always @(negedge clk) begin
    if (rst !== 1'b0) begin
      p_vld = 1'b0;
    end else begin
      if (p_vld && !p_rdy) begin
        chk("stall_vld",  32'(sif.out_vld),  32'd1);
        chk("stall_dat",  sif.out_dat,       p_dat);
        chk("stall_idx",  32'(sif.out_idx),  32'(p_idx));
        chk("stall_last", 32'(sif.out_last), 32'(p_last));
      end
      if (sif.out_vld) begin
        chk("elem_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          chk("elem_dat",  sif.out_dat,       exp_q[0].dat);
          chk("elem_idx",  32'(sif.out_idx),  32'(exp_q[0].idx));
          chk("elem_last", 32'(sif.out_last), 32'(exp_q[0].last));
          if (sif.out_rdy) begin
            obs_t o;
            o.dat  = sif.out_dat;
            o.idx  = sif.out_idx;
            o.last = sif.out_last;
            o.cyc  = cyc;
            obs_q.push_back(o);
            void'(exp_q.pop_front());
          end
        end
      end
      if (done) begin
        chk("done_all_consumed", 32'(exp_q.size()), 32'd0);
        chk("done_busy",         32'(busy),         32'd1);
        done_cnt++;
        done_cyc = cyc;
      end
      chk("rd_addr_known", 32'($isunknown({rd_reg_addr, rd_el_addr})), 32'd0);
      p_vld  = sif.out_vld;
      p_rdy  = sif.out_rdy;
      p_dat  = sif.out_dat;
      p_idx  = sif.out_idx;
      p_last = sif.out_last;
    end
  end

  // Consumer ready: always high, or the repeating 1,0,0 stall pattern.
  initial begin
    sif.out_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      sif.out_rdy = (rdy_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input int b, input int s, input int l, input int v, output int n, output int c0);
    base_reg = 5'(b);
    sew      = 3'(s);
    lmul     = 3'(l);
    vl       = 7'(v);
    start    = 1'b1;
    c0       = cyc;
    n        = model_push(b, s, l, v);
    step();
    start    = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < budget; i++) begin
      if (done_cnt != d0) break;
      step();
    end
    chk(name, 32'(done_cnt - d0), 32'd1);
    step();
  endtask

  initial begin
    int n, c0, d0;
    #200000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n, c0, d0;
    for (int r = 0; r < 32; r++)
      for (int b = 0; b < 16; b++)
        vreg[r][b*8 +: 8] = 8'(r * 16 + b);
    vreg[3] = 128'h44444444_33333333_22222222_11111111;
    rf_sw    = 32;
    rst      = 1'b1;
    start    = 1'b0;
    base_reg = '0;
    sew      = '0;
    lmul     = '0;
    vl       = '0;
    repeat (3) step();
    rst = 1'b0;
    step();

    // Reset state
    chk("rst_vld",     32'(sif.out_vld),  32'd0);
    chk("rst_last",    32'(sif.out_last), 32'd0);
    chk("rst_dat",     sif.out_dat,       32'd0);
    chk("rst_idx",     32'(sif.out_idx),  32'd0);
    chk("rst_busy",    32'(busy),         32'd0);
    chk("rst_done",    32'(done),         32'd0);
    chk("rst_rd_reg",  32'(rd_reg_addr),  32'd0);
    chk("rst_rd_el",   32'(rd_el_addr),   32'd0);

    // 1: SEW32, one register, four elements at full rate
    rdy_mode = 0; rf_sw = 32; obs_q.delete();
    launch(3, 2, 0, 4, n, c0);
    chk("t1_busy_after_start", 32'(busy),        32'd1);
    chk("t1_no_vld_yet",       32'(sif.out_vld), 32'd0);
    wait_done("t1_done", 50);
    chk("t1_count",    32'(obs_q.size()), 32'd4);
    if (obs_q.size() == 4) begin
      chk("t1_first_cyc", 32'(obs_q[0].cyc - c0), 32'd2);
      chk("t1_dat0",      obs_q[0].dat,           32'h11111111);
      chk("t1_dat1",      obs_q[1].dat,           32'h22222222);
      chk("t1_dat3",      obs_q[3].dat,           32'h44444444);
      chk("t1_last",      32'(obs_q[3].last),     32'd1);
      chk("t1_idx3",      32'(obs_q[3].idx),      32'd3);
      chk("t1_back2back", 32'(obs_q[3].cyc - obs_q[0].cyc), 32'd3);
      chk("t1_done_cyc",  32'(done_cyc - obs_q[3].cyc),     32'd1);
    end
    chk("t1_idle_busy", 32'(busy), 32'd0);

    // 2: SEW8 across v30 -> v31
    rf_sw = 8; obs_q.delete();
    launch(30, 0, 1, 20, n, c0);
    wait_done("t2_done", 100);
    chk("t2_count", 32'(obs_q.size()), 32'd20);
    if (obs_q.size() == 20) begin
      chk("t2_dat0",  obs_q[0].dat,       32'h000000E0);
      chk("t2_dat15", obs_q[15].dat,      32'h000000EF);
      chk("t2_dat16", obs_q[16].dat,      32'h000000F0);
      chk("t2_dat19", obs_q[19].dat,      32'h000000F3);
      chk("t2_last",  32'(obs_q[19].last), 32'd1);
    end

    // 3: SEW16, four registers from v31 wrapping to v0, vl clamped 40 -> 32
    rf_sw = 16; obs_q.delete();
    launch(31, 1, 2, 40, n, c0);
    chk("t3_model_clamp", 32'(n), 32'd32);
    wait_done("t3_done", 150);
    chk("t3_count", 32'(obs_q.size()), 32'd32);
    if (obs_q.size() == 32) begin
      chk("t3_dat0",  obs_q[0].dat,        32'h0000F1F0);
      chk("t3_dat8",  obs_q[8].dat,        32'h00000100);
      chk("t3_dat31", obs_q[31].dat,       32'h00002F2E);
      chk("t3_idx31", 32'(obs_q[31].idx),  32'd31);
      chk("t3_last",  32'(obs_q[31].last), 32'd1);
    end

    // 4: backpressure, plus a start pulse mid-stream that must be ignored
    rdy_mode = 1; rf_sw = 32; obs_q.delete();
    launch(5, 2, 1, 5, n, c0);
    step(); step();
    base_reg = 5'd0; sew = 3'd7; lmul = 3'd2; vl = 7'd2; start = 1'b1;
    step();
    start = 1'b0;
    wait_done("t4_done", 100);
    chk("t4_count", 32'(obs_q.size()), 32'd5);
    if (obs_q.size() == 5) begin
      chk("t4_dat0", obs_q[0].dat,      32'h53525150);
      chk("t4_dat4", obs_q[4].dat,      32'h63626160);
      chk("t4_idx4", 32'(obs_q[4].idx), 32'd4);
    end
    rdy_mode = 0;
    step();

    // 5: vl=0 -> straight to FIN
    obs_q.delete();
    launch(7, 2, 0, 0, n, c0);
    chk("t5_busy",  32'(busy),        32'd1);
    chk("t5_done",  32'(done),        32'd1);
    chk("t5_vld",   32'(sif.out_vld), 32'd0);
    step();
    chk("t5_busy_off", 32'(busy), 32'd0);
    chk("t5_done_off", 32'(done), 32'd0);
    chk("t5_no_elems", 32'(obs_q.size()), 32'd0);

    // 6: reset after three of eight elements, then a clean rerun
    rf_sw = 32; obs_q.delete();
    launch(10, 2, 1, 8, n, c0);
    for (int i = 0; i < 50; i++) begin
      if (obs_q.size() >= 3) break;
      step();
    end
    chk("t6_partial", 32'(obs_q.size()), 32'd3);
    d0  = done_cnt;
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
    chk("t6_rst_vld",  32'(sif.out_vld), 32'd0);
    chk("t6_rst_busy", 32'(busy),        32'd0);
    chk("t6_rst_done", 32'(done),        32'd0);
    repeat (4) step();
    chk("t6_no_done", 32'(done_cnt - d0), 32'd0);
    obs_q.delete();
    launch(10, 2, 1, 8, n, c0);
    wait_done("t6_rerun_done", 60);
    chk("t6_rerun_count", 32'(obs_q.size()), 32'd8);
    if (obs_q.size() == 8) begin
      chk("t6_rerun_idx0", 32'(obs_q[0].idx), 32'd0);
      chk("t6_rerun_dat0", obs_q[0].dat,      32'hA3A2A1A0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
